// File: rtl/tsc_param.sv
// tsc_param: parametrised trigger-sequence controller (timebase arm, N-input match, event count, sticky trigger).
// Optional idle-gap decay of the event count is built when TSC_TIMEOUT_EN is defined.
module tsc_param #(
  parameter int N_COND    = 2,
  parameter int CNT_W     = 8,
  parameter int ARM_AT    = 128,
  parameter int EVT_W     = 8,
  parameter int THRESH    = 128,
  parameter int MATCH_ANY = 0,
  parameter int GAP       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [N_COND-1:0] cond,
  output logic              trigger,
  output logic [1:0]        state,
  output logic [EVT_W-1:0]  evt_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ARMED = 2'd2,
    FIRED = 2'd3
  } st_t;

  localparam logic [CNT_W-1:0] TB_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] ARM_V  = CNT_W'(ARM_AT);
  localparam logic [CNT_W-1:0] ARM_M1 = CNT_W'(ARM_AT - 1);
  localparam logic [EVT_W-1:0] EV_ONE = EVT_W'(1);
  localparam logic [EVT_W-1:0] THR_V  = EVT_W'(THRESH);
  localparam logic [EVT_W-1:0] THR_M1 = EVT_W'(THRESH - 1);

  if (N_COND < 1 || N_COND > 16) begin : g_bad_ncond
    $error("tsc_param: N_COND out of range");
  end
  if (ARM_AT < 1 || ARM_AT > (2**CNT_W) - 1) begin : g_bad_arm
    $error("tsc_param: ARM_AT out of range");
  end
  if (THRESH < 1 || THRESH > (2**EVT_W) - 1) begin : g_bad_thr
    $error("tsc_param: THRESH out of range");
  end
  if (GAP < 1 || GAP > (2**CNT_W) - 1) begin : g_bad_gap
    $error("tsc_param: GAP out of range");
  end

  st_t              st_q, st_d;
  logic [CNT_W-1:0] tb_q, tb_d;
  logic [EVT_W-1:0] ev_q, ev_d;
  logic             match;

  assign match = (MATCH_ANY != 0) ? |cond : &cond;

`ifdef TSC_TIMEOUT_EN
  localparam logic [CNT_W-1:0] GAP_V  = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP - 1);
  logic [CNT_W-1:0] gp_q, gp_d;

  // Idle-gap counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) gp_q <= '0;
    else     gp_q <= gp_d;
  end
`endif

  // State, timebase and event-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      tb_q <= '0;
      ev_q <= '0;
    end else begin
      st_q <= st_d;
      tb_q <= tb_d;
      ev_q <= ev_d;
    end
  end

  // Next-state, timebase, event and gap logic.
  always_comb begin
    st_d = st_q;
    tb_d = tb_q;
    ev_d = ev_q;
`ifdef TSC_TIMEOUT_EN
    gp_d = gp_q;
`endif
    if (clr) begin
      st_d = IDLE;
      tb_d = '0;
      ev_d = '0;
`ifdef TSC_TIMEOUT_EN
      gp_d = '0;
`endif
    end else if (en) begin
      unique case (st_q)
        IDLE: begin
          tb_d = TB_ONE;
          st_d = (ARM_V == TB_ONE) ? ARMED : WAIT;
        end
        WAIT: begin
          if (tb_q == ARM_M1) begin
            st_d = ARMED;
            tb_d = ARM_V;
          end else begin
            tb_d = tb_q + TB_ONE;
          end
        end
        ARMED: begin
          if (match) begin
`ifdef TSC_TIMEOUT_EN
            gp_d = '0;
`endif
            if (ev_q == THR_M1) begin
              ev_d = THR_V;
              st_d = FIRED;
            end else begin
              ev_d = ev_q + EV_ONE;
            end
          end else begin
`ifdef TSC_TIMEOUT_EN
            if (gp_q == GAP_M1 && ev_q != '0) begin
              ev_d = '0;
              gp_d = '0;
            end else if (gp_q != GAP_V) begin
              gp_d = gp_q + TB_ONE;
            end
`endif
          end
        end
        FIRED: begin
          st_d = FIRED;
        end
        default: begin
          st_d = IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only; no path from cond to trigger.
  always_comb begin
    trigger = (st_q == FIRED);
    state   = st_q;
    evt_cnt = ev_q;
  end

endmodule

// File: tb/tb_tsc_param.sv
// tb_tsc_param: directed bench for tsc_param (defaults plus a MATCH_ANY=1 twin).
// Timeout checks follow TSC_TIMEOUT_EN.
module tb_tsc_param;
  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [1:0] cond;
  logic       trig;
  logic [1:0] st;
  logic [7:0] ev;
  logic       trig_a;
  logic [1:0] st_a;
  logic [7:0] ev_a;

  int n_chk;
  int n_fail;

  tsc_param dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .cond(cond),
    .trigger(trig), .state(st), .evt_cnt(ev)
  );

  tsc_param #(.MATCH_ANY(1)) dut_any (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .cond(cond),
    .trigger(trig_a), .state(st_a), .evt_cnt(ev_a)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    ticks(1);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++;
    if (st !== 2'd0) begin
      n_fail++; $display("FAIL reset_state got %0d want 0", st);
    end
    n_chk++;
    if (trig !== 1'b0) begin
      n_fail++; $display("FAIL reset_trig got %0b want 0", trig);
    end
    n_chk++;
    if (ev !== 8'd0) begin
      n_fail++; $display("FAIL reset_evt got %0d want 0", ev);
    end
  endtask

  task automatic test_arm_fire();
    en = 1'b1;
    cond = 2'b11;
    ticks(127);
    n_chk++;
    if (st !== 2'd1) begin
      n_fail++; $display("FAIL arm_wait127 got %0d want 1", st);
    end
    ticks(1);
    n_chk++;
    if (st !== 2'd2 || ev !== 8'd0) begin
      n_fail++; $display("FAIL arm_at128 got st=%0d ev=%0d want st=2 ev=0", st, ev);
    end
    ticks(127);
    n_chk++;
    if (trig !== 1'b0 || ev !== 8'd127 || st !== 2'd2) begin
      n_fail++;
      $display("FAIL pre_fire got trig=%0b ev=%0d st=%0d want 0/127/2", trig, ev, st);
    end
    ticks(1);
    n_chk++;
    if (trig !== 1'b1 || ev !== 8'd128 || st !== 2'd3) begin
      n_fail++;
      $display("FAIL fire got trig=%0b ev=%0d st=%0d want 1/128/3", trig, ev, st);
    end
    n_chk++;
    if (trig_a !== 1'b1) begin
      n_fail++; $display("FAIL fire_any got %0b want 1", trig_a);
    end
    cond = 2'b00;
    ticks(5);
    en = 1'b0;
    ticks(3);
    n_chk++;
    if (trig !== 1'b1 || ev !== 8'd128 || st !== 2'd3) begin
      n_fail++;
      $display("FAIL sticky got trig=%0b ev=%0d st=%0d want 1/128/3", trig, ev, st);
    end
  endtask

  task automatic test_clr();
    do_clr();
    n_chk++;
    if (st !== 2'd0 || trig !== 1'b0 || ev !== 8'd0) begin
      n_fail++;
      $display("FAIL clr got st=%0d trig=%0b ev=%0d want 0/0/0", st, trig, ev);
    end
  endtask

  task automatic test_match_any();
    en = 1'b1;
    cond = 2'b00;
    ticks(128);
    n_chk++;
    if (st !== 2'd2 || st_a !== 2'd2) begin
      n_fail++; $display("FAIL any_arm got %0d/%0d want 2/2", st, st_a);
    end
    for (int i = 0; i < 127; i++) begin
      cond = 2'b01;
      ticks(1);
      cond = 2'b00;
      ticks(1);
    end
    n_chk++;
    if (trig_a !== 1'b0 || ev_a !== 8'd127) begin
      n_fail++; $display("FAIL any_127 got trig=%0b ev=%0d want 0/127", trig_a, ev_a);
    end
    cond = 2'b01;
    ticks(1);
    cond = 2'b00;
    n_chk++;
    if (trig_a !== 1'b1 || ev_a !== 8'd128) begin
      n_fail++; $display("FAIL any_fire got trig=%0b ev=%0d want 1/128", trig_a, ev_a);
    end
    n_chk++;
    if (trig !== 1'b0 || ev !== 8'd0) begin
      n_fail++; $display("FAIL all_nofire got trig=%0b ev=%0d want 0/0", trig, ev);
    end
    do_clr();
  endtask

  task automatic test_wait_only();
    en = 1'b1;
    cond = 2'b11;
    ticks(128);
    cond = 2'b00;
    ticks(20);
    n_chk++;
    if (st !== 2'd2 || ev !== 8'd0 || trig !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_only got st=%0d ev=%0d trig=%0b want 2/0/0", st, ev, trig);
    end
    do_clr();
  endtask

  task automatic test_en_freeze();
    en = 1'b1;
    cond = 2'b00;
    ticks(50);
    en = 1'b0;
    ticks(10);
    n_chk++;
    if (st !== 2'd1) begin
      n_fail++; $display("FAIL freeze_hold got %0d want 1", st);
    end
    en = 1'b1;
    ticks(77);
    n_chk++;
    if (st !== 2'd1) begin
      n_fail++; $display("FAIL freeze_shift127 got %0d want 1", st);
    end
    ticks(1);
    n_chk++;
    if (st !== 2'd2) begin
      n_fail++; $display("FAIL freeze_shift128 got %0d want 2", st);
    end
  endtask

  task automatic test_rst_mid();
    cond = 2'b11;
    ticks(5);
    n_chk++;
    if (ev !== 8'd5) begin
      n_fail++; $display("FAIL rst_pre got %0d want 5", ev);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (st !== 2'd0 || ev !== 8'd0 || trig !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async got st=%0d ev=%0d trig=%0b want 0/0/0", st, ev, trig);
    end
    #2;
    rst = 1'b0;
    cond = 2'b00;
    ticks(1);
    n_chk++;
    if (st !== 2'd1) begin
      n_fail++; $display("FAIL rst_resume got %0d want 1", st);
    end
    do_clr();
  endtask

  task automatic test_clr_race();
    en = 1'b1;
    cond = 2'b11;
    ticks(128 + 127);
    n_chk++;
    if (ev !== 8'd127) begin
      n_fail++; $display("FAIL race_pre got %0d want 127", ev);
    end
    clr = 1'b1;
    ticks(1);
    clr = 1'b0;
    n_chk++;
    if (trig !== 1'b0 || st !== 2'd0 || ev !== 8'd0) begin
      n_fail++;
      $display("FAIL race_clr got trig=%0b st=%0d ev=%0d want 0/0/0", trig, st, ev);
    end
    cond = 2'b00;
    ticks(2);
    n_chk++;
    if (trig !== 1'b0) begin
      n_fail++; $display("FAIL race_after got %0b want 0", trig);
    end
    do_clr();
  endtask

  task automatic test_timeout();
    logic [7:0] exp1;
    logic [7:0] exp2;
`ifdef TSC_TIMEOUT_EN
    exp1 = 8'd0;
    exp2 = 8'd11;
`else
    exp1 = 8'd10;
    exp2 = 8'd21;
`endif
    en = 1'b1;
    cond = 2'b00;
    ticks(128);
    cond = 2'b11;
    ticks(10);
    cond = 2'b00;
    ticks(16);
    n_chk++;
    if (ev !== exp1 || st !== 2'd2) begin
      n_fail++; $display("FAIL gap16 got ev=%0d st=%0d want %0d/2", ev, st, exp1);
    end
    cond = 2'b11;
    ticks(10);
    cond = 2'b00;
    ticks(15);
    cond = 2'b11;
    ticks(1);
    cond = 2'b00;
    n_chk++;
    if (ev !== exp2 || st !== 2'd2) begin
      n_fail++; $display("FAIL gap15 got ev=%0d st=%0d want %0d/2", ev, st, exp2);
    end
    do_clr();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    en = 1'b0;
    clr = 1'b0;
    cond = 2'b00;
    #3;
    test_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_arm_fire();
    test_clr();
    test_match_any();
    test_wait_only();
    test_en_freeze();
    test_rst_mid();
    test_clr_race();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tsc_param.md
Name: tsc_param

Overview:
- Parametrised trigger-sequence controller for the benchmark suite; successor to the fixed two-input, 8-bit trigger controller.
- A free-running timebase arms the block after ARM_AT cycles. An N-input rare-condition matcher (all-of or any-of) then feeds an event counter.
- Asserts a sticky registered trigger when THRESH matches have accumulated. Exposes state and count for observation by detection benches.
- Sits beside the host datapath (e.g. AES core); consumes host signals as condition inputs and drives payload-enable logic.

Parameters:
- N_COND, 2, number of condition inputs (1..16).
- CNT_W, 8, timebase counter width.
- ARM_AT, 128, timebase value at which matching is armed (1..2^CNT_W-1).
- EVT_W, 8, event counter width.
- THRESH, 128, match count that fires the trigger (1..2^EVT_W-1).
- MATCH_ANY, 0, 0 = match when all cond bits high; 1 = match when any cond bit high.
- GAP, 16, idle-cycle limit used only by the optional feature (1..2^CNT_W-1).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; 0 freezes all state.
- clr  input  1  synchronous clear to IDLE; priority over en.
- cond  input  N_COND  rare-condition inputs.
- trigger  output  1  registered, sticky trigger.
- state  output  2  current FSM state: IDLE=0, WAIT=1, ARMED=2, FIRED=3.
- evt_cnt  output  EVT_W  current event count.

Behaviour:
- Reset (async, rst=1): state=IDLE, timebase=0, evt_cnt=0, trigger=0, gap counter=0. All registers clear immediately, including mid-operation; the block resumes from IDLE on the first edge after rst falls.
- clr=1 on an edge: same values as reset, applied synchronously, in any state, regardless of en.
- en=0 (clr=0): every register holds its value, including in FIRED.
- match = MATCH_ANY ? |cond : &cond. cond is sampled on the clock edge with no synchronisers; cond is already in the clk domain.
- IDLE, en=1: go to WAIT; timebase becomes 1.
- WAIT, en=1: timebase +1 per edge.
  - On the edge where timebase == ARM_AT-1, go to ARMED with timebase=ARM_AT.
  - ARM_AT=1: the IDLE edge loads timebase=1 and goes directly to ARMED.
  - Timebase then saturates at ARM_AT and never wraps.
  - Matches in WAIT are ignored.
- ARMED, en=1, match=1:
  - If evt_cnt == THRESH-1: evt_cnt becomes THRESH, state becomes FIRED, trigger becomes 1, all on the same edge.
  - Otherwise evt_cnt +1.
- ARMED, match=0: evt_cnt holds.
- FIRED: trigger=1, evt_cnt=THRESH, timebase frozen, cond ignored. Leaves only by clr or rst.
- Trigger latency: trigger is visible the cycle after the THRESH-th qualifying match edge; there is no combinational path from cond to trigger.
- evt_cnt never exceeds THRESH, so it cannot wrap.
- Simultaneous clr and the firing match: clr wins, and trigger stays 0.

Optional Feature:
- Macro TSC_TIMEOUT_EN.
- Defined:
  - In ARMED, the gap counter increments on each en=1 edge with match=0 and clears on a match.
  - When it reaches GAP while evt_cnt>0, evt_cnt and the gap counter clear to 0 on that edge; state stays ARMED.
  - Matches must therefore be dense for the trigger to fire.
- Not defined: no gap counter is built, GAP is ignored, and evt_cnt never decays.

Test Plan:
- rst pulse mid-ARMED with evt_cnt=5 -> trigger=0, state=0, evt_cnt=0 immediately, before the next clk edge.
- Defaults, en=1, cond=2'b11 held -> state=ARMED after 128 edges from IDLE exit; trigger=1 exactly 128 edges later; evt_cnt=128.
- MATCH_ANY=1, cond=2'b01 pulsed every other cycle after arming -> trigger=1 after the 128th pulse; with MATCH_ANY=0 the same stimulus leaves trigger=0 and evt_cnt=0.
- cond=2'b11 during WAIT only, then 0 -> evt_cnt=0, trigger never asserts; en=0 for 10 cycles mid-WAIT -> the arm point shifts by exactly 10 cycles.
- FIRED, then clr=1 for one cycle -> state=IDLE, trigger=0 next edge. clr coincident with the 128th match -> trigger stays 0.
- TSC_TIMEOUT_EN, GAP=16: 10 matches, then 16 idle cycles -> evt_cnt=0, state=ARMED; 15 idle cycles then a match -> evt_cnt=11.
